regfile_param: RTL and testbench

- Parametrised multi-entry register file; next generation of the team's 4x32 register file.
- Configurable data width and entry count.
- One synchronous write port and two registered read ports with 1-cycle latency.
- Write-first bypass, per-entry "written" tracking, and read-valid strobes.
- Sits between instruction decode and the ALU in the single-cycle/multi-cycle datapath labs.

---
 rtl/regfile_param_if.sv | 34 +++
 rtl/regfile_param.sv | 109 ++++++++++
 tb/tb_regfile_param.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/regfile_param_if.sv
// Register-file bus: one write port and two read request/response ports.
// The master drives requests; the slave (register file) drives read responses.
interface regfile_param_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 2
) ();
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic              ReadEn1;
    logic [ADDR_W-1:0] ReadReg1;
    logic              ReadEn2;
    logic [ADDR_W-1:0] ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic              ReadValid1;
    logic              ReadValid2;
    logic              ReadWritten1;
    logic              ReadWritten2;

    modport master (
        output RegWrite, WriteReg, WriteData,
        output ReadEn1, ReadReg1, ReadEn2, ReadReg2,
        input  ReadData1, ReadData2, ReadValid1, ReadValid2,
        input  ReadWritten1, ReadWritten2
    );

    modport slave (
        input  RegWrite, WriteReg, WriteData,
        input  ReadEn1, ReadReg1, ReadEn2, ReadReg2,
        output ReadData1, ReadData2, ReadValid1, ReadValid2,
        output ReadWritten1, ReadWritten2
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: one write port, two 1-cycle registered read ports
// with write-first bypass and per-entry written flags. Optional macro
// REGFILE_ZERO_REG_EN hardwires entry 0 to zero.
module regfile_param #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic           clk,
    input  logic           reset,
    regfile_param_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(NREGS);

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    generate
        if (NREGS < 2 || NREGS > 64 || (64'(1) << ADDR_W) < 64'(NREGS)) begin : g_bad_cfg
            $error("regfile_param: illegal NREGS/ADDR_W combination");
        end
    endgenerate

    logic [DATA_W-1:0] r_mem [NREGS];
    logic [NREGS-1:0]  r_written;
    logic [DATA_W-1:0] r_rdata1;
    logic [DATA_W-1:0] r_rdata2;
    logic              r_rvalid1;
    logic              r_rvalid2;
    logic              r_rwritten1;
    logic              r_rwritten2;

    logic              w_wr_ok;
    logic [DATA_W:0]   w_rd1;
    logic [DATA_W:0]   w_rd2;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < NREGS;
    endfunction

    // {written, data} a read of address a would capture on this edge
    function automatic logic [DATA_W:0] read_lookup(input logic [ADDR_W-1:0] a);
        logic [DATA_W:0] res;
        res = '0;
        if (!in_range(a)) begin
            res = '0;
        end else if (ZERO_REG && a == '0) begin
            res = {1'b1, {DATA_W{1'b0}}};
        end else if (w_wr_ok && a == bus.WriteReg) begin
            res = {1'b1, bus.WriteData};
        end else begin
            res = {r_written[IDX_W'(a)], r_mem[IDX_W'(a)]};
        end
        return res;
    endfunction

    assign w_wr_ok = bus.RegWrite && in_range(bus.WriteReg)
                     && !(ZERO_REG && bus.WriteReg == '0);

    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        w_rd1 = read_lookup(bus.ReadReg1);
        w_rd2 = read_lookup(bus.ReadReg2);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_mem[IDX_W'(i)] <= '0;
            end
            r_written   <= '0;
            r_rdata1    <= '0;
            r_rdata2    <= '0;
            r_rvalid1   <= 1'b0;
            r_rvalid2   <= 1'b0;
            r_rwritten1 <= 1'b0;
            r_rwritten2 <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_mem[IDX_W'(bus.WriteReg)]     <= bus.WriteData;
                r_written[IDX_W'(bus.WriteReg)] <= 1'b1;
            end
            // Data and written flag hold when the port is idle; valid is a strobe
            r_rvalid1 <= bus.ReadEn1;
            r_rvalid2 <= bus.ReadEn2;
            if (bus.ReadEn1) begin
                r_rdata1    <= w_rd1[DATA_W-1:0];
                r_rwritten1 <= w_rd1[DATA_W];
            end
            if (bus.ReadEn2) begin
                r_rdata2    <= w_rd2[DATA_W-1:0];
                r_rwritten2 <= w_rd2[DATA_W];
            end
        end
    end

    assign bus.ReadData1    = r_rdata1;
    assign bus.ReadData2    = r_rdata2;
    assign bus.ReadValid1   = r_rvalid1;
    assign bus.ReadValid2   = r_rvalid2;
    assign bus.ReadWritten1 = r_rwritten1;
    assign bus.ReadWritten2 = r_rwritten2;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param (NREGS=5, ADDR_W=3): directed steps plus a random
// burst, expected read responses queued at drive time and checked after the edge.
module tb_regfile_param;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREGS  = 5;
    localparam int unsigned ADDR_W = 3;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    typedef struct {
        logic        v1;
        logic [31:0] d1;
        logic        w1;
        logic        v2;
        logic [31:0] d2;
        logic        w2;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    regfile_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_param #(.DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    exp_t        sb[$];
    exp_t        cur;
    logic [31:0] m_mem [NREGS];
    logic        m_wr  [NREGS];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference read: returns what a read of ra captures on an edge with this write
    task automatic model_read(input int ra, input logic wr_ok, input int wa,
                              input logic [31:0] wd, output logic [31:0] d, output logic w);
        if (ra >= int'(NREGS)) begin
            d = 32'h0; w = 1'b0;
        end else if (ZR && ra == 0) begin
            d = 32'h0; w = 1'b1;
        end else if (wr_ok && ra == wa) begin
            d = wd; w = 1'b1;
        end else begin
            d = m_mem[ra]; w = m_wr[ra];
        end
    endtask

    task automatic step(input logic rst_n, input logic we, input int wa, input logic [31:0] wd,
                        input logic re1, input int ra1, input logic re2, input int ra2,
                        input string tag);
        exp_t        e;
        logic        wr_ok;
        logic [31:0] d;
        logic        w;
        reset         = rst_n;
        bus.RegWrite  = we;
        bus.WriteReg  = 3'(wa);
        bus.WriteData = wd;
        bus.ReadEn1   = re1;
        bus.ReadReg1  = 3'(ra1);
        bus.ReadEn2   = re2;
        bus.ReadReg2  = 3'(ra2);
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                m_mem[i] = 32'h0;
                m_wr[i]  = 1'b0;
            end
            cur = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
        end else begin
            wr_ok = we && wa < int'(NREGS) && !(ZR && wa == 0);
            cur.v1 = re1;
            cur.v2 = re2;
            if (re1) begin
                model_read(ra1, wr_ok, wa, wd, d, w);
                cur.d1 = d; cur.w1 = w;
            end
            if (re2) begin
                model_read(ra2, wr_ok, wa, wd, d, w);
                cur.d2 = d; cur.w2 = w;
            end
            if (wr_ok) begin
                m_mem[wa] = wd;
                m_wr[wa]  = 1'b1;
            end
        end
        sb.push_back(cur);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s: scoreboard empty, observed 0 entries expected 1", tag);
        end else begin
            e = sb.pop_front();
            check({tag, ".valid1"},   32'(bus.ReadValid1),   32'(e.v1));
            check({tag, ".data1"},    bus.ReadData1,         e.d1);
            check({tag, ".written1"}, 32'(bus.ReadWritten1), 32'(e.w1));
            check({tag, ".valid2"},   32'(bus.ReadValid2),   32'(e.v2));
            check({tag, ".data2"},    bus.ReadData2,         e.d2);
            check({tag, ".written2"}, 32'(bus.ReadWritten2), 32'(e.w2));
        end
    endtask

    initial begin
        reset         = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.WriteReg  = '0;
        bus.WriteData = '0;
        bus.ReadEn1   = 1'b0;
        bus.ReadReg1  = '0;
        bus.ReadEn2   = 1'b0;
        bus.ReadReg2  = '0;

        // reset for two cycles, then read reg 0
        step(0, 0, 0, 32'h0, 0, 0, 0, 0, "rst0");
        step(0, 0, 0, 32'h0, 0, 0, 0, 0, "rst1");
        step(1, 0, 0, 32'h0, 1, 0, 0, 0, "rd_after_rst");

        // write then read both ports
        step(1, 1, 0, 32'hBFAFAFAF, 0, 0, 0, 0, "wr0");
        step(1, 1, 1, 32'hCFAFAFAF, 0, 0, 0, 0, "wr1");
        step(1, 0, 0, 32'h0, 1, 0, 1, 1, "rd01");

        // write-first bypass on both ports, then plain read
        step(1, 1, 2, 32'h12345678, 1, 2, 1, 2, "bypass2");
        step(1, 0, 0, 32'h0, 1, 2, 0, 0, "rd2");

        // single read pulse, then idle: valid drops, data holds
        step(1, 0, 0, 32'h0, 1, 1, 0, 0, "pulse1");
        step(1, 0, 0, 32'h0, 0, 1, 0, 0, "hold_a");
        step(1, 0, 0, 32'h0, 0, 1, 0, 0, "hold_b");
        step(1, 0, 0, 32'h0, 0, 1, 0, 0, "hold_c");

        // out-of-range write ignored, out-of-range reads give 0/valid/unwritten
        step(1, 1, 6, 32'h0000DEAD, 1, 6, 1, 5, "oor_wr_rd");
        step(1, 1, 4, 32'hA5A5A5A5, 1, 4, 1, 7, "last_entry_bypass");
        step(1, 0, 0, 32'h0, 1, 3, 1, 4, "rd34");
        step(1, 0, 0, 32'h0, 1, 1, 1, 1, "same_addr");

        // reset beats a simultaneous write and read
        step(1, 1, 3, 32'h0000AAAA, 0, 0, 0, 0, "wr3");
        step(0, 1, 3, 32'h0000BBBB, 1, 3, 1, 3, "rst_vs_wr");
        step(1, 0, 0, 32'h0, 1, 3, 1, 0, "rd3_after_rst");

        // write all-ones to reg 0 with same-edge read; later read again
        step(1, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, "zero_wr_rd");
        step(1, 0, 0, 32'h0, 1, 0, 1, 0, "zero_rd");

        // random traffic with occasional reset
        for (int k = 0; k < 60; k++) begin
            step(($urandom_range(0, 24) != 0), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                 $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
